// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: physical register tag, FSM state and entry record.
package rob_pkg;

  localparam int unsigned PHY_REG_W = 7;

  typedef logic [PHY_REG_W-1:0] phy_reg_t;

  typedef enum logic {
    NORMAL,
    REWIND
  } rob_state_e;

  typedef struct packed {
    logic     has_dst;
    phy_reg_t phy_dst;
    phy_reg_t phy_dst_old;
    logic     done;
    logic     mispredict;
  } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Dispatch/complete/retire/rewind bundle between the rename/execute stages (master) and the ROB (slave).
interface rob_if #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned WIDTH = 2
);
  import rob_pkg::*;

  localparam int unsigned IDX_LEN = $clog2(SIZE);
  localparam int unsigned RC_LEN  = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]              dispatch_valid;
  logic [WIDTH-1:0]              dispatch_has_dst;
  phy_reg_t [WIDTH-1:0]          dispatch_phy_dst;
  phy_reg_t [WIDTH-1:0]          dispatch_phy_dst_old;
  logic                          dispatch_ready;
  logic [WIDTH-1:0][IDX_LEN-1:0] dispatch_rob_idx;

  logic [WIDTH-1:0]              complete_valid;
  logic [WIDTH-1:0][IDX_LEN-1:0] complete_rob_idx;
  logic [WIDTH-1:0]              complete_mispredict;

  logic [WIDTH-1:0]              retire_valid;
  phy_reg_t [WIDTH-1:0]          retire_phy_dst_old;
  logic [RC_LEN-1:0]             retire_count;

  logic [WIDTH-1:0]              rewind_valid;
  phy_reg_t [WIDTH-1:0]          rewind_phy_dst;
  logic                          rewind_busy;

  modport master (
    output dispatch_valid, dispatch_has_dst, dispatch_phy_dst, dispatch_phy_dst_old,
    output complete_valid, complete_rob_idx, complete_mispredict,
    input  dispatch_ready, dispatch_rob_idx,
    input  retire_valid, retire_phy_dst_old, retire_count,
    input  rewind_valid, rewind_phy_dst, rewind_busy
  );

  modport slave (
    input  dispatch_valid, dispatch_has_dst, dispatch_phy_dst, dispatch_phy_dst_old,
    input  complete_valid, complete_rob_idx, complete_mispredict,
    output dispatch_ready, dispatch_rob_idx,
    output retire_valid, retire_phy_dst_old, retire_count,
    output rewind_valid, rewind_phy_dst, rewind_busy
  );

endinterface

// File: rtl/rob_retire_sel.sv
// Picks the in-order commit run from head: consecutive done entries, ending after a mispredict.
module rob_retire_sel #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_avail,
  input  logic [WIDTH-1:0] i_done,
  input  logic [WIDTH-1:0] i_mispredict,
  output logic [WIDTH-1:0] o_mask,
  output logic             o_mispredict
);

  logic w_run;

  always_comb begin
    o_mask       = '0;
    o_mispredict = 1'b0;
    w_run        = i_en;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_run && i_avail[i] && i_done[i]) begin
        o_mask[i] = 1'b1;
        if (i_mispredict[i]) begin
          o_mispredict = 1'b1;
          w_run        = 1'b0;
        end
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order commit of out-of-order completions, with tail walk-back after a mispredict.
// Define ROB_COMPLETE_BYPASS_EN to let a completion to the head entry retire in the same cycle.
module rob #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned WIDTH = 2
) (
  input logic  i_clock,
  input logic  i_reset,
  rob_if.slave rob_bus
);
  import rob_pkg::*;

  localparam int unsigned IDX_LEN = $clog2(SIZE);
  localparam int unsigned CNT_LEN = $clog2(SIZE + 1);
  localparam int unsigned RC_LEN  = $clog2(WIDTH + 1);
  localparam logic [CNT_LEN-1:0] READY_MAX = CNT_LEN'(SIZE - WIDTH);

  rob_entry_t         r_entry [SIZE];
  logic [SIZE-1:0]    r_valid;
  logic [IDX_LEN-1:0] r_head;
  logic [IDX_LEN-1:0] r_tail;
  logic [CNT_LEN-1:0] r_count;
  rob_state_e         r_state;
  rob_state_e         w_state_next;

  logic               w_ready;
  logic [RC_LEN-1:0]  w_disp_run;
  logic [RC_LEN-1:0]  w_n_acc;
  logic [RC_LEN-1:0]  w_n_ret;
  logic [RC_LEN-1:0]  w_n_rw;
  logic [IDX_LEN-1:0] w_disp_idx [WIDTH];
  logic [IDX_LEN-1:0] w_ret_idx  [WIDTH];
  logic [IDX_LEN-1:0] w_rw_idx   [WIDTH];
  logic [WIDTH-1:0]   w_avail;
  logic [WIDTH-1:0]   w_done;
  logic [WIDTH-1:0]   w_misp;
  logic [WIDTH-1:0]   w_ret_mask;
  logic [WIDTH-1:0]   w_rw_act;
  logic               w_ret_misp;
  logic [CNT_LEN-1:0] w_count_next;

  // Valid lanes pack onto consecutive slots from tail, skipping idle lanes.
  always_comb begin
    w_ready    = (r_state == NORMAL) && (r_count <= READY_MAX);
    w_disp_run = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_disp_idx[i] = r_tail + IDX_LEN'(w_disp_run);
      if (rob_bus.dispatch_valid[i]) w_disp_run = w_disp_run + RC_LEN'(1);
    end
    w_n_acc = w_ready ? w_disp_run : '0;
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_ret_idx[i] = r_head + IDX_LEN'(i);
      w_avail[i]   = (CNT_LEN'(i) < r_count) && r_valid[w_ret_idx[i]];
      w_done[i]    = r_entry[w_ret_idx[i]].done;
      w_misp[i]    = r_entry[w_ret_idx[i]].mispredict;
    end
`ifdef ROB_COMPLETE_BYPASS_EN
    for (int j = 0; j < WIDTH; j++) begin
      if (rob_bus.complete_valid[j] && !rob_bus.complete_mispredict[j] &&
          (rob_bus.complete_rob_idx[j] == r_head) && (r_state == NORMAL)) begin
        w_done[0] = 1'b1;
      end
    end
`endif
  end

  rob_retire_sel #(
    .WIDTH (WIDTH)
  ) u_retire_sel (
    .i_en         (r_state == NORMAL),
    .i_avail      (w_avail),
    .i_done       (w_done),
    .i_mispredict (w_misp),
    .o_mask       (w_ret_mask),
    .o_mispredict (w_ret_misp)
  );

  // Rewind lane 0 is the youngest entry (tail - 1).
  always_comb begin
    w_n_ret = '0;
    w_n_rw  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_rw_idx[i] = r_tail - IDX_LEN'(i + 1);
      w_rw_act[i] = (r_state == REWIND) && (CNT_LEN'(i) < r_count);
      if (w_ret_mask[i]) w_n_ret = w_n_ret + RC_LEN'(1);
      if (w_rw_act[i])   w_n_rw  = w_n_rw + RC_LEN'(1);
    end
    w_count_next = r_count + CNT_LEN'(w_n_acc) - CNT_LEN'(w_n_ret) - CNT_LEN'(w_n_rw);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= NORMAL;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      NORMAL:  if (w_ret_misp) w_state_next = REWIND;
      REWIND:  if (w_count_next == '0) w_state_next = NORMAL;
      default: w_state_next = NORMAL;
    endcase
  end

  always_comb begin
    rob_bus.dispatch_ready     = !i_reset && w_ready;
    rob_bus.dispatch_rob_idx   = '0;
    rob_bus.retire_valid       = '0;
    rob_bus.retire_phy_dst_old = '0;
    rob_bus.retire_count       = i_reset ? '0 : w_n_ret;
    rob_bus.rewind_valid       = '0;
    rob_bus.rewind_phy_dst     = '0;
    rob_bus.rewind_busy        = !i_reset && (r_state == REWIND);
    if (!i_reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        rob_bus.dispatch_rob_idx[i] = w_disp_idx[i];
        if (w_ret_mask[i] && r_entry[w_ret_idx[i]].has_dst) begin
          rob_bus.retire_valid[i]       = 1'b1;
          rob_bus.retire_phy_dst_old[i] = r_entry[w_ret_idx[i]].phy_dst_old;
        end
        if (w_rw_act[i] && r_entry[w_rw_idx[i]].has_dst) begin
          rob_bus.rewind_valid[i]   = 1'b1;
          rob_bus.rewind_phy_dst[i] = r_entry[w_rw_idx[i]].phy_dst;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int k = 0; k < SIZE; k++) r_entry[k] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_ready && rob_bus.dispatch_valid[i]) begin
          r_entry[w_disp_idx[i]] <= '{has_dst:     rob_bus.dispatch_has_dst[i],
                                      phy_dst:     rob_bus.dispatch_phy_dst[i],
                                      phy_dst_old: rob_bus.dispatch_phy_dst_old[i],
                                      done:        1'b0,
                                      mispredict:  1'b0};
          r_valid[w_disp_idx[i]] <= 1'b1;
        end
        if ((r_state == NORMAL) && rob_bus.complete_valid[i] &&
            r_valid[rob_bus.complete_rob_idx[i]]) begin
          r_entry[rob_bus.complete_rob_idx[i]].done       <= 1'b1;
          r_entry[rob_bus.complete_rob_idx[i]].mispredict <= rob_bus.complete_mispredict[i];
        end
        if (w_ret_mask[i]) r_valid[w_ret_idx[i]] <= 1'b0;
        if (w_rw_act[i])   r_valid[w_rw_idx[i]]  <= 1'b0;
      end
      r_head  <= r_head + IDX_LEN'(w_n_ret);
      r_tail  <= r_tail + IDX_LEN'(w_n_acc) - IDX_LEN'(w_n_rw);
      r_count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob (SIZE=32, WIDTH=2): one vector per clock cycle, inputs plus expected outputs.
module tb_rob;
  import rob_pkg::*;

  typedef struct {
    logic       rst;
    logic [1:0] dv, dh;
    logic [6:0] d0, o0, d1, o1;
    logic [1:0] cv;
    logic [4:0] c0, c1;
    logic [1:0] cm;
    logic       rdy;
    logic [4:0] x0, x1;
    logic [1:0] rv;
    logic [6:0] ro0, ro1;
    logic [1:0] rc;
    logic [1:0] wv;
    logic [6:0] w0, w1;
    logic       wb;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t tbl [23];

  rob_if #(.SIZE(32), .WIDTH(2)) bus ();

  rob #(.SIZE(32), .WIDTH(2)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .rob_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input int id, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec %0d %s: got %0d, expected %0d", id, what, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int id);
    @(posedge clk);
    #1;
    rst                         = v.rst;
    bus.dispatch_valid          = v.dv;
    bus.dispatch_has_dst        = v.dh;
    bus.dispatch_phy_dst[0]     = v.d0;
    bus.dispatch_phy_dst[1]     = v.d1;
    bus.dispatch_phy_dst_old[0] = v.o0;
    bus.dispatch_phy_dst_old[1] = v.o1;
    bus.complete_valid          = v.cv;
    bus.complete_rob_idx[0]     = v.c0;
    bus.complete_rob_idx[1]     = v.c1;
    bus.complete_mispredict     = v.cm;
    @(negedge clk);
    chk(id, "dispatch_ready", 32'(bus.dispatch_ready), 32'(v.rdy));
    if (v.dv[0]) chk(id, "dispatch_rob_idx0", 32'(bus.dispatch_rob_idx[0]), 32'(v.x0));
    if (v.dv[1]) chk(id, "dispatch_rob_idx1", 32'(bus.dispatch_rob_idx[1]), 32'(v.x1));
    chk(id, "retire_valid", 32'(bus.retire_valid), 32'(v.rv));
    chk(id, "retire_count", 32'(bus.retire_count), 32'(v.rc));
    if (v.rv[0]) chk(id, "retire_old0", 32'(bus.retire_phy_dst_old[0]), 32'(v.ro0));
    if (v.rv[1]) chk(id, "retire_old1", 32'(bus.retire_phy_dst_old[1]), 32'(v.ro1));
    chk(id, "rewind_valid", 32'(bus.rewind_valid), 32'(v.wv));
    chk(id, "rewind_busy", 32'(bus.rewind_busy), 32'(v.wb));
    if (v.wv[0]) chk(id, "rewind_dst0", 32'(bus.rewind_phy_dst[0]), 32'(v.w0));
    if (v.wv[1]) chk(id, "rewind_dst1", 32'(bus.rewind_phy_dst[1]), 32'(v.w1));
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{rdy: 1, default: 0};
    return v;
  endfunction

  function automatic vec_t rst_vec();
    vec_t v;
    v = '{rst: 1, default: 0};
    return v;
  endfunction

  initial begin
    vec_t v;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.dispatch_valid       = '0;
    bus.dispatch_has_dst     = '0;
    bus.dispatch_phy_dst     = '0;
    bus.dispatch_phy_dst_old = '0;
    bus.complete_valid       = '0;
    bus.complete_rob_idx     = '0;
    bus.complete_mispredict  = '0;

    // Basic dual commit, then in-order commit with a mispredict and rewind walk.
    tbl[0]  = '{rst: 1, default: 0};
    tbl[1]  = '{dv: 3, dh: 3, d0: 40, o0: 5, d1: 41, o1: 6, rdy: 1, x0: 0, x1: 1, default: 0};
    tbl[2]  = '{cv: 3, c0: 0, c1: 1, rdy: 1, default: 0};
    tbl[3]  = '{rdy: 1, rv: 3, ro0: 5, ro1: 6, rc: 2, default: 0};
    tbl[4]  = '{rdy: 1, default: 0};
    tbl[5]  = '{rst: 1, default: 0};
    tbl[6]  = '{dv: 3, dh: 3, d0: 40, o0: 1, d1: 41, o1: 2, rdy: 1, x0: 0, x1: 1, default: 0};
    tbl[7]  = '{dv: 3, dh: 3, d0: 42, o0: 3, d1: 43, o1: 4, rdy: 1, x0: 2, x1: 3, default: 0};
    tbl[8]  = '{dv: 3, dh: 3, d0: 44, o0: 5, d1: 45, o1: 6, rdy: 1, x0: 4, x1: 5,
                cv: 1, c0: 1, default: 0};
    tbl[9]  = '{cv: 1, c0: 2, cm: 1, rdy: 1, default: 0};
    tbl[10] = '{cv: 1, c0: 3, rdy: 1, default: 0};
    tbl[11] = '{cv: 1, c0: 0, rdy: 1, default: 0};
    tbl[12] = '{rdy: 1, rv: 3, ro0: 1, ro1: 2, rc: 2, default: 0};
    tbl[13] = '{rdy: 1, rv: 1, ro0: 3, rc: 1, default: 0};
    tbl[14] = '{wv: 3, w0: 45, w1: 44, wb: 1, default: 0};
    tbl[15] = '{wv: 1, w0: 43, wb: 1, default: 0};
    tbl[16] = '{dv: 1, dh: 1, d0: 50, o0: 9, rdy: 1, x0: 3, default: 0};
    tbl[17] = '{dv: 3, dh: 1, d0: 51, o0: 11, d1: 52, o1: 12, rdy: 1, x0: 4, x1: 5, default: 0};
    tbl[18] = '{cv: 3, c0: 3, c1: 4, rdy: 1, default: 0};
    tbl[19] = '{rdy: 1, rv: 3, ro0: 9, ro1: 11, rc: 2, default: 0};
    tbl[20] = '{cv: 1, c0: 5, rdy: 1, default: 0};
    tbl[21] = '{rdy: 1, rc: 1, default: 0};
    tbl[22] = '{rdy: 1, default: 0};

    for (int t = 0; t < 23; t++) run(tbl[t], t);

    // Fill to 31 and 32 entries; ready must drop and come back once two retire.
    run(rst_vec(), 100);
    for (int k = 0; k < 15; k++) begin
      v = idle();
      v.dv = 2'b11; v.dh = 2'b11;
      v.d0 = 7'(2 * k); v.o0 = 7'(2 * k); v.d1 = 7'(2 * k + 1); v.o1 = 7'(2 * k + 1);
      v.x0 = 5'(2 * k); v.x1 = 5'(2 * k + 1);
      run(v, 101);
    end
    v = idle(); v.dv = 2'b01; v.dh = 2'b01; v.d0 = 100; v.o0 = 100; v.x0 = 30;
    run(v, 102);
    v = idle(); v.rdy = 0; v.cv = 2'b01; v.c0 = 0;
    run(v, 103);
    v = idle(); v.rdy = 0; v.rv = 2'b01; v.ro0 = 0; v.rc = 1;
    run(v, 104);
    v = idle(); v.dv = 2'b11; v.dh = 2'b11; v.d0 = 101; v.o0 = 101; v.d1 = 102; v.o1 = 102;
    v.x0 = 31; v.x1 = 0;
    run(v, 105);
    v = idle(); v.rdy = 0; v.cv = 2'b11; v.c0 = 1; v.c1 = 2;
    run(v, 106);
    v = idle(); v.rdy = 0; v.rv = 2'b11; v.ro0 = 1; v.ro1 = 2; v.rc = 2;
    run(v, 107);
    run(idle(), 108);

    // Advance head to 30, then allocate across the wrap and commit in order.
    run(rst_vec(), 200);
    for (int k = 0; k < 15; k++) begin
      v = idle();
      v.dv = 2'b11; v.dh = 2'b11;
      v.d0 = 7'(2 * k); v.o0 = 7'(2 * k); v.d1 = 7'(2 * k + 1); v.o1 = 7'(2 * k + 1);
      v.x0 = 5'(2 * k); v.x1 = 5'(2 * k + 1);
      run(v, 201);
    end
    for (int k = 0; k < 15; k++) begin
      v = idle();
      v.cv = 2'b11; v.c0 = 5'(2 * k); v.c1 = 5'(2 * k + 1);
      if (k > 0) begin
        v.rv = 2'b11; v.ro0 = 7'(2 * k - 2); v.ro1 = 7'(2 * k - 1); v.rc = 2;
      end
      run(v, 202);
    end
    v = idle(); v.rv = 2'b11; v.ro0 = 28; v.ro1 = 29; v.rc = 2;
    run(v, 203);
    v = idle(); v.dv = 2'b11; v.dh = 2'b11; v.d0 = 60; v.o0 = 20; v.d1 = 61; v.o1 = 21;
    v.x0 = 30; v.x1 = 31;
    run(v, 204);
    v = idle(); v.dv = 2'b11; v.dh = 2'b11; v.d0 = 62; v.o0 = 22; v.d1 = 63; v.o1 = 23;
    v.x0 = 0; v.x1 = 1;
    run(v, 205);
    v = idle(); v.cv = 2'b11; v.c0 = 0; v.c1 = 1;
    run(v, 206);
    v = idle(); v.cv = 2'b11; v.c0 = 30; v.c1 = 31;
    run(v, 207);
    v = idle(); v.rv = 2'b11; v.ro0 = 20; v.ro1 = 21; v.rc = 2;
    run(v, 208);
    v = idle(); v.rv = 2'b11; v.ro0 = 22; v.ro1 = 23; v.rc = 2;
    run(v, 209);
    run(idle(), 210);

    // Reset in the middle of a rewind walk.
    run(rst_vec(), 300);
    v = idle(); v.dv = 2'b11; v.dh = 2'b11; v.d0 = 70; v.o0 = 30; v.d1 = 71; v.o1 = 31;
    v.x0 = 0; v.x1 = 1;
    run(v, 301);
    v = idle(); v.dv = 2'b11; v.dh = 2'b11; v.d0 = 72; v.o0 = 32; v.d1 = 73; v.o1 = 33;
    v.x0 = 2; v.x1 = 3; v.cv = 2'b01; v.c0 = 0; v.cm = 2'b01;
    run(v, 302);
    v = idle(); v.rv = 2'b01; v.ro0 = 30; v.rc = 1;
    run(v, 303);
    v = idle(); v.rdy = 0; v.wv = 2'b11; v.w0 = 73; v.w1 = 72; v.wb = 1;
    run(v, 304);
    run(rst_vec(), 305);
    v = idle(); v.dv = 2'b11; v.dh = 2'b11; v.d0 = 80; v.o0 = 40; v.d1 = 81; v.o1 = 41;
    v.x0 = 0; v.x1 = 1;
    run(v, 306);
    run(idle(), 307);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 SHALL have parameter SIZE, default 32, meaning ROB entry count (power of two, >= 2*WIDTH).
REQ-002 SHALL have parameter WIDTH, default 2, meaning dispatch/complete/retire/rewind lanes per cycle.
REQ-003 clock  in  1  single clock, all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 dispatch_valid  in  WIDTH  per-lane allocate request, lanes in program order (lane 0 oldest).
REQ-006 dispatch_has_dst  in  WIDTH  lane writes a physical destination.
REQ-007 dispatch_phy_dst / dispatch_phy_dst_old  in  WIDTH x phy_reg_t  new and previous mapping of the destination.
REQ-008 dispatch_ready  out  1  ROB accepts up to WIDTH entries this cycle.
REQ-009 dispatch_rob_idx  out  WIDTH x IDX_LEN  entry index assigned to each valid lane.
REQ-010 complete_valid  in  WIDTH; complete_rob_idx  in  WIDTH x IDX_LEN; complete_mispredict  in  WIDTH  execution-done reports.
REQ-011 retire_valid  out  WIDTH; retire_phy_dst_old  out  WIDTH x phy_reg_t  registers returned to free list on commit.
REQ-012 retire_count  out  clog2(WIDTH+1)  instructions committed this cycle.
REQ-013 rewind_valid  out  WIDTH; rewind_phy_dst  out  WIDTH x phy_reg_t  squashed destinations returned to free list.
REQ-014 rewind_busy  out  1  high while in REWIND state.

Function
REQ-015 SHALL be a circular buffer with head, tail, count; indices wrap modulo SIZE.
REQ-016 dispatch_ready SHALL equal (state==NORMAL && count <= SIZE-WIDTH), computed from registered state only.
REQ-017 Valid lanes accepted when ready SHALL occupy consecutive entries from tail; dispatch_rob_idx[i] = tail + (valid lanes below i).
REQ-018 Completion SHALL set the entry's done bit (and mispredict bit) at the next posedge; completions to invalid entries or during REWIND SHALL be ignored.
REQ-019 Retire SHALL commit the longest run, up to WIDTH, of consecutive done entries from head, stopping after the first mispredicted entry.
REQ-020 retire_valid[i] SHALL be asserted only for committed entries with has_dst; retire_count counts all committed entries.
REQ-021 Committing a mispredicted entry SHALL transition NORMAL->REWIND at the next edge; all younger entries are squashed.
REQ-022 In REWIND, each cycle SHALL pop up to WIDTH youngest entries from tail, lane 0 youngest, asserting rewind_valid only for has_dst entries.
REQ-023 REWIND->NORMAL SHALL occur the cycle after count reaches 0; dispatch resumes that cycle.
REQ-024 Dispatch and retire in the same cycle SHALL both take effect; count_next = count + accepted - retired.
REQ-025 Full (count==SIZE) and empty (count==0) SHALL be distinguished by count, not pointer equality.

Reset
REQ-026 On reset: head=tail=count=0, state NORMAL, all valid/done/mispredict bits cleared.
REQ-027 Reset SHALL hold all outputs 0 except dispatch_ready, which is 1 the first cycle after reset.
REQ-028 Reset asserted mid-REWIND SHALL abort the walk with no further rewind_valid pulses.

Configuration
REQ-029 With ROB_COMPLETE_BYPASS_EN defined, a completion to the entry at head (non-mispredict) SHALL allow retire in the same cycle.
REQ-030 Without ROB_COMPLETE_BYPASS_EN, completion-to-retire latency SHALL be exactly one cycle.

Structure
REQ-031 phy_reg_t, rob_state_e (NORMAL, REWIND) and rob_entry_t (has_dst, phy_dst, phy_dst_old, done, mispredict) SHALL live in the shared package.
REQ-032 Sub-module rob_retire_sel SHALL compute the consecutive-done retire mask from head.

Verification (SIZE=32, WIDTH=2)
REQ-033 Dispatch 2 lanes dst 40/41 old 5/6, complete both -> next cycle retire_valid=2'b11, phy_dst_old 5,6, retire_count=2.
REQ-034 Dispatch 32 entries -> dispatch_ready low at count 31 and 32; retire 2 -> ready high next cycle.
REQ-035 Entries 0..5 dst 40..45, complete 1 out of order -> no retire until entry 0 completes, then 0,1 retire same cycle.
REQ-036 Entry 2 mispredict, entries 3..5 dispatched -> entry 2 retires, rewind emits 45,44 then 43, rewind_busy 2 cycles, ready after.
REQ-037 Head at 30, dispatch 4 -> indices 30,31,0,1; retire order preserved across wrap.
REQ-038 Reset during REWIND -> next cycle rewind_valid=0, count=0, dispatch_ready=1.
